isq_issue_arbiter: RTL and testbench

//  Shares one execution/issue port between NUM_REQ issue queues (each an age-buffer dequeue side).

---
 rtl/isq_issue_arbiter.sv | 121 ++++++++++++
 tb/tb_isq_issue_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/isq_issue_arbiter.sv
// Issue-port arbiter: grants the oldest ready issue-queue packet (by ROB id
// with wrap bit) into a single output register, with a starvation guard and
// rollback flush of the held entry.
module isq_issue_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = 248,
  parameter int ROB_SIZE_LOG = 6,
  parameter int ROBID_LSB    = 241,
  parameter int STARVE_LIMIT = 8,
  parameter logic [1:0] ROB_STATE_ROLLBACK = 2'd2,
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]              out_src,
  input  logic                          out_ready,
  input  logic [1:0]                    rob_state,
  input  logic                          flush_valid,
  input  logic [ROB_SIZE_LOG:0]         flush_robid
);

  localparam int ROBID_W = ROB_SIZE_LOG + 1;
  localparam int CNT_W   = (STARVE_LIMIT > 2) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT - 1);

  // a is older than b: same wrap bit compares indices directly, differing
  // wrap bits mean the larger index was allocated before the wrap.
  function automatic logic is_older(input logic [ROBID_W-1:0] a,
                                    input logic [ROBID_W-1:0] b);
    if (a[ROBID_W-1] == b[ROBID_W-1])
      return a[ROBID_W-2:0] < b[ROBID_W-2:0];
    else
      return a[ROBID_W-2:0] > b[ROBID_W-2:0];
  endfunction

  // Entry e is strictly younger than flush point f (equal ids survive).
  function automatic logic is_younger(input logic [ROBID_W-1:0] f,
                                      input logic [ROBID_W-1:0] e);
    return f[ROBID_W-1] ^ e[ROBID_W-1] ^ (f[ROBID_W-2:0] < e[ROBID_W-2:0]);
  endfunction

  logic [ROBID_W-1:0] req_robid [NUM_REQ];
  logic [CNT_W-1:0]   starve_cnt [NUM_REQ];
  logic [SRC_W-1:0]   winner;
  logic               starving;
  logic               have_cand;
  logic               rollback;
  logic               block;
  logic               can_accept;
  logic               grant_en;
  logic               kill_held;

  assign rollback   = (rob_state == ROB_STATE_ROLLBACK);
  assign block      = rollback | flush_valid;
  assign can_accept = ~out_valid | out_ready;
  assign grant_en   = ~reset & can_accept & ~block & (|req_valid);
  assign kill_held  = flush_valid & rollback & out_valid &
                      is_younger(flush_robid, out_data[ROBID_LSB +: ROBID_W]);

  // Winner selection: a starving requester first, otherwise the oldest robid.
  always_comb begin
    winner    = '0;
    starving  = 1'b0;
    have_cand = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_robid[i] = req_data[i*DATA_WIDTH + ROBID_LSB +: ROBID_W];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && (starve_cnt[i] == CNT_MAX) && !starving) begin
        winner   = SRC_W'(i);
        starving = 1'b1;
      end
    end
    if (!starving) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && (!have_cand || is_older(req_robid[i], req_robid[winner]))) begin
          winner    = SRC_W'(i);
          have_cand = 1'b1;
        end
      end
    end
  end

  // One-hot dequeue strobe back to the chosen queue.
  always_comb begin
    req_ready = '0;
    if (grant_en) req_ready[winner] = 1'b1;
  end

  // Output register: refill on grant, drop on flush kill or consumption.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (grant_en) begin
      out_valid <= 1'b1;
      out_data  <= req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
      out_src   <= winner;
    end else if (kill_held || out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Starvation counters count consecutive denials while the port could accept.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset || block || !req_valid[i] || req_ready[i]) begin
        starve_cnt[i] <= '0;
      end else if (can_accept && (starve_cnt[i] != CNT_MAX)) begin
        starve_cnt[i] <= starve_cnt[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_isq_issue_arbiter.sv
// Bench for isq_issue_arbiter: directed vector table, hand sequences for
// starvation and reset, then random traffic against a behavioural model.
module tb_isq_issue_arbiter;

  localparam int DW = 248;
  localparam logic [1:0] RB = 2'd2;

  logic          clock;
  logic          reset;
  logic [1:0]    req_valid;
  logic [2*DW-1:0] req_data;
  logic [1:0]    req_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [0:0]    out_src;
  logic          out_ready;
  logic [1:0]    rob_state;
  logic          flush_valid;
  logic [6:0]    flush_robid;

  isq_issue_arbiter #(
    .NUM_REQ(2), .DATA_WIDTH(DW), .ROB_SIZE_LOG(6), .ROBID_LSB(241),
    .STARVE_LIMIT(8), .ROB_STATE_ROLLBACK(RB)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready), .rob_state(rob_state),
    .flush_valid(flush_valid), .flush_robid(flush_robid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_src;
  int            m_cnt [2];

  // Last sampled DUT values
  logic [1:0]    s_rr;
  logic          s_ov;
  logic          s_src;
  logic [DW-1:0] s_data;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Age as modular distance: a older than b iff b lies 1..63 ahead of a.
  function automatic bit older(input logic [6:0] a, input logic [6:0] b);
    int d;
    d = (int'(b) - int'(a)) & 127;
    return (d >= 1) && (d <= 63);
  endfunction

  // e younger than flush point f iff e lies 1..64 ahead of f.
  function automatic bit younger(input logic [6:0] e, input logic [6:0] f);
    int d;
    d = (int'(e) - int'(f)) & 127;
    return (d >= 1) && (d <= 64);
  endfunction

  function automatic logic [DW-1:0] mk(input logic [6:0] rid);
    logic [255:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    return {rid, t[240:0]};
  endfunction

  task automatic drive(input logic r, input logic [1:0] rv, input logic [DW-1:0] d0,
                       input logic [DW-1:0] d1, input logic ordy, input logic [1:0] rs,
                       input logic fv, input logic [6:0] fr);
    logic [6:0] rid [2];
    logic [1:0] exp_rr;
    bit can, blk, gnt;
    int w;
    reset = r; req_valid = rv; req_data = {d1, d0}; out_ready = ordy;
    rob_state = rs; flush_valid = fv; flush_robid = fr;
    rid[0] = d0[DW-1 -: 7];
    rid[1] = d1[DW-1 -: 7];
    can = !m_valid || ordy;
    blk = (rs == RB) || fv;
    w = -1;
    for (int i = 0; i < 2; i++)
      if (rv[i] && m_cnt[i] == 7 && w < 0) w = i;
    if (w < 0)
      for (int i = 0; i < 2; i++)
        if (rv[i] && (w < 0 || older(rid[i], rid[w]))) w = i;
    gnt = !r && can && !blk && (rv != 2'b00);
    exp_rr = gnt ? 2'(1 << w) : 2'b00;
    @(negedge clock);
    s_rr = req_ready;
    chk("req_ready", DW'(s_rr), DW'(exp_rr));
    // model next state
    for (int i = 0; i < 2; i++) begin
      if (r || blk || !rv[i] || (gnt && w == i)) m_cnt[i] = 0;
      else if (can && m_cnt[i] < 7) m_cnt[i] = m_cnt[i] + 1;
    end
    if (r) begin
      m_valid = 1'b0; m_data = '0; m_src = 0;
    end else if (gnt) begin
      m_valid = 1'b1; m_data = (w == 0) ? d0 : d1; m_src = w;
    end else if (fv && rs == RB && m_valid && younger(m_data[DW-1 -: 7], fr)) begin
      m_valid = 1'b0;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clock);
    #1;
    s_ov = out_valid; s_src = out_src; s_data = out_data;
    chk("out_valid", DW'(s_ov), DW'(m_valid));
    chk("out_src", DW'(s_src), DW'(m_src));
    chk("out_data", s_data, m_data);
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] rv;
    logic [6:0] r0, r1;
    logic       ordy;
    logic [1:0] rs;
    logic       fv;
    logic [6:0] fr;
    logic [1:0] e_rr;
    logic       e_ov;
    logic       e_src;
  } vec_t;

  vec_t tbl [$];

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
    rob_state = 2'd0; flush_valid = 1'b0; flush_robid = '0;
    m_valid = 1'b0; m_data = '0; m_src = 0; m_cnt[0] = 0; m_cnt[1] = 0;

    //            rst rv     r0     r1     rdy rs    fv  fr     rr     ov  src
    tbl.push_back('{1, 2'b11, 7'h05, 7'h06, 1, 2'd0, 0, 7'h00, 2'b00, 0, 0});
    tbl.push_back('{0, 2'b01, 7'h05, 7'h06, 1, 2'd0, 0, 7'h00, 2'b01, 1, 0});
    tbl.push_back('{0, 2'b11, 7'h45, 7'h3E, 1, 2'd0, 0, 7'h00, 2'b10, 1, 1});
    tbl.push_back('{0, 2'b00, 7'h00, 7'h00, 1, 2'd0, 0, 7'h00, 2'b00, 0, 1});
    tbl.push_back('{0, 2'b01, 7'h10, 7'h11, 1, 2'd0, 0, 7'h00, 2'b01, 1, 0});
    tbl.push_back('{0, 2'b11, 7'h10, 7'h11, 0, 2'd0, 0, 7'h00, 2'b00, 1, 0});
    tbl.push_back('{0, 2'b11, 7'h10, 7'h11, 0, 2'd0, 0, 7'h00, 2'b00, 1, 0});
    tbl.push_back('{0, 2'b11, 7'h10, 7'h11, 0, 2'd0, 0, 7'h00, 2'b00, 1, 0});
    tbl.push_back('{0, 2'b01, 7'h0A, 7'h11, 1, 2'd0, 0, 7'h00, 2'b01, 1, 0});
    tbl.push_back('{0, 2'b11, 7'h0A, 7'h11, 0, RB,   1, 7'h08, 2'b00, 0, 0});
    tbl.push_back('{0, 2'b01, 7'h0A, 7'h11, 1, 2'd0, 0, 7'h00, 2'b01, 1, 0});
    tbl.push_back('{0, 2'b11, 7'h0A, 7'h11, 0, RB,   1, 7'h0A, 2'b00, 1, 0});
    tbl.push_back('{0, 2'b11, 7'h0A, 7'h11, 1, RB,   0, 7'h00, 2'b00, 0, 0});
    tbl.push_back('{0, 2'b11, 7'h20, 7'h20, 1, 2'd0, 0, 7'h00, 2'b01, 1, 0});
    tbl.push_back('{0, 2'b11, 7'h3E, 7'h45, 1, 2'd0, 0, 7'h00, 2'b01, 1, 0});
    tbl.push_back('{0, 2'b10, 7'h00, 7'h7F, 1, 2'd0, 0, 7'h00, 2'b10, 1, 1});

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].rv, mk(tbl[k].r0), mk(tbl[k].r1), tbl[k].ordy,
            tbl[k].rs, tbl[k].fv, tbl[k].fr);
      chk($sformatf("tbl%0d_rr", k), DW'(s_rr), DW'(tbl[k].e_rr));
      chk($sformatf("tbl%0d_ov", k), DW'(s_ov), DW'(tbl[k].e_ov));
      chk($sformatf("tbl%0d_src", k), DW'(s_src), DW'(tbl[k].e_src));
    end

    // Starvation: q0 always older; q1 must win on its 8th request cycle.
    drive(1, 2'b00, '0, '0, 1, 2'd0, 0, 7'h00);
    for (int c = 1; c <= 10; c++) begin
      drive(0, 2'b11, mk(7'h01), mk(7'h02), 1, 2'd0, 0, 7'h00);
      chk($sformatf("starve_c%0d", c), DW'(s_rr), (c == 8) ? DW'(2'b10) : DW'(2'b01));
    end

    // Reset while holding a packet with nonzero counters.
    drive(0, 2'b11, mk(7'h01), mk(7'h02), 0, 2'd0, 0, 7'h00);
    drive(1, 2'b11, mk(7'h01), mk(7'h02), 1, 2'd0, 0, 7'h00);
    chk("rst_rr", DW'(s_rr), DW'(2'b00));
    chk("rst_ov", DW'(s_ov), DW'(1'b0));
    chk("rst_data", s_data, '0);
    for (int c = 1; c <= 8; c++) begin
      drive(0, 2'b11, mk(7'h01), mk(7'h02), 1, 2'd0, 0, 7'h00);
      chk($sformatf("post_rst_c%0d", c), DW'(s_rr), (c == 8) ? DW'(2'b10) : DW'(2'b01));
    end

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      logic [6:0] base;
      base = 7'($urandom);
      drive(($urandom_range(0, 49) == 0),
            2'($urandom),
            mk(base + 7'($urandom_range(0, 3))),
            mk(($urandom_range(0, 3) == 0) ? 7'($urandom) : base + 7'($urandom_range(0, 3))),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 6) == 0) ? RB : 2'($urandom_range(0, 1)),
            ($urandom_range(0, 6) == 0),
            base + 7'($urandom_range(0, 4)) - 7'd2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
